// File: rtl/steer_en_gen_if.sv
// Load-cell sample bus into the steer-enable controller and its status outputs.
// master drives the samples; slave is the controller.
interface steer_en_gen_if #(
  parameter int LD_W = 12
);
  logic            ld_vld;
  logic [LD_W-1:0] lft_ld;
  logic [LD_W-1:0] rght_ld;
  logic            rider_off;
  logic            en_steer;
  logic [1:0]      st;

  modport master (output ld_vld, lft_ld, rght_ld, input  rider_off, en_steer, st);
  modport slave  (input  ld_vld, lft_ld, rght_ld, output rider_off, en_steer, st);
endinterface

// File: rtl/steer_en_gen.sv
// Rider-presence / steering-enable controller: qualifies the captured load-cell
// samples and walks OFF -> SETTLE -> STEER, with a debounced EXIT on weight dips.
module steer_en_gen #(
  parameter int LD_W          = 12,
  parameter int MIN_WT        = 'h200,
  parameter int HYST          = 'h40,
  parameter int SETTLE_CYCLES = 67_000_000,
  parameter int FAST_SETTLE   = 32768,
  parameter int OFF_DEB       = 16,
  parameter bit FAST_SIM      = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  steer_en_gen_if.slave bus
);
  localparam int N    = FAST_SIM ? FAST_SETTLE : SETTLE_CYCLES;
  localparam int TMAX = (SETTLE_CYCLES > OFF_DEB) ? SETTLE_CYCLES : OFF_DEB;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [LD_W:0] LO_TH  = (LD_W+1)'(MIN_WT - HYST);
  localparam logic [LD_W:0] HI_TH  = (LD_W+1)'(MIN_WT + HYST);
  localparam logic [TW-1:0] N_M1   = TW'(N - 1);
  localparam logic [TW-1:0] DEB_M1 = TW'(OFF_DEB - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_SETTLE = 2'd1,
    S_STEER  = 2'd2,
    S_EXIT   = 2'd3
  } state_t;

  state_t          r_state, w_nxt;
  logic [LD_W-1:0] r_lft, r_rght;
  logic [TW-1:0]   r_tmr, w_tmr_nxt, w_tmr_inc;
  logic            r_rider_off, r_en_steer;

  logic [LD_W:0]   w_sum;
  logic [LD_W-1:0] w_adiff;
  logic            w_lo, w_hi, w_imb, w_big_imb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft  <= '0;
      r_rght <= '0;
    end else if (bus.ld_vld) begin
      r_lft  <= bus.lft_ld;
      r_rght <= bus.rght_ld;
    end
  end

  // Difference taken in the larger-minus-smaller order so it never wraps.
  assign w_sum     = {1'b0, r_lft} + {1'b0, r_rght};
  assign w_adiff   = (r_lft >= r_rght) ? (r_lft - r_rght) : (r_rght - r_lft);
  assign w_lo      = w_sum < LO_TH;
  assign w_hi      = w_sum > HI_TH;
  assign w_imb     = {1'b0, w_adiff} > (w_sum >> 2);
  assign w_big_imb = {1'b0, w_adiff} > (w_sum - (w_sum >> 4));

  assign w_tmr_inc = (r_tmr == '1) ? r_tmr : r_tmr + 1'b1;

  always_comb begin
    w_nxt     = r_state;
    w_tmr_nxt = '0;
    unique case (r_state)
      S_OFF: begin
        if (w_hi) w_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_lo)               w_nxt = S_OFF;
        else if (w_imb)         w_nxt = S_SETTLE;
        else if (r_tmr == N_M1) w_nxt = S_STEER;
        else                    w_tmr_nxt = w_tmr_inc;
      end
      S_STEER: begin
        if (w_lo)           w_nxt = S_EXIT;
        else if (w_big_imb) w_nxt = S_SETTLE;
      end
      S_EXIT: begin
        // Imbalance is deliberately ignored while debouncing a weight dip.
        if (!w_lo)                w_nxt = S_STEER;
        else if (r_tmr == DEB_M1) w_nxt = S_OFF;
        else                      w_tmr_nxt = w_tmr_inc;
      end
      default: w_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_OFF;
      r_tmr       <= '0;
      r_rider_off <= 1'b1;
      r_en_steer  <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_tmr       <= w_tmr_nxt;
      r_rider_off <= (w_nxt == S_OFF);
      r_en_steer  <= (w_nxt == S_STEER) || (w_nxt == S_EXIT);
    end
  end

  assign bus.st        = r_state;
  assign bus.rider_off = r_rider_off;
  assign bus.en_steer  = r_en_steer;
endmodule

// File: tb/tb_steer_en_gen.sv
// Directed bench for steer_en_gen: walks the rider state machine through
// settle, steer, dip/exit, threshold edges and asynchronous reset.
module tb_steer_en_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  steer_en_gen_if #(.LD_W(12)) bus ();

  steer_en_gen #(.LD_W(12), .FAST_SIM(1'b1), .FAST_SETTLE(32768), .OFF_DEB(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input logic [11:0] l, input logic [11:0] r);
    bus.ld_vld = 1'b1; bus.lft_ld = l; bus.rght_ld = r;
    tick(1);
    bus.ld_vld = 1'b0;
  endtask

  task automatic test_reset;
    bus.ld_vld = 1'b0; bus.lft_ld = '0; bus.rght_ld = '0;
    rst_n = 1'b0;
    tick(2);
    nvec++;
    if (bus.st !== 2'd0 || bus.rider_off !== 1'b1 || bus.en_steer !== 1'b0) begin
      nerr++; $display("FAIL reset st=%0d roff=%0b en=%0b exp 0/1/0", bus.st, bus.rider_off, bus.en_steer);
    end
    rst_n = 1'b1;
    tick(3);
    nvec++;
    if (bus.st !== 2'd0 || bus.rider_off !== 1'b1) begin
      nerr++; $display("FAIL reset_hold st=%0d roff=%0b exp 0/1", bus.st, bus.rider_off);
    end
  endtask

  task automatic test_settle;
    load(12'h150, 12'h150);
    tick(1);
    nvec++;
    if (bus.st !== 2'd1 || bus.en_steer !== 1'b0 || bus.rider_off !== 1'b0) begin
      nerr++; $display("FAIL settle_entry st=%0d en=%0b roff=%0b exp 1/0/0", bus.st, bus.en_steer, bus.rider_off);
    end
    tick(32767);
    nvec++;
    if (bus.st !== 2'd1 || bus.en_steer !== 1'b0) begin
      nerr++; $display("FAIL settle_early st=%0d en=%0b exp 1/0", bus.st, bus.en_steer);
    end
    tick(1);
    nvec++;
    if (bus.st !== 2'd2 || bus.en_steer !== 1'b1 || bus.rider_off !== 1'b0) begin
      nerr++; $display("FAIL settle_done st=%0d en=%0b roff=%0b exp 2/1/0", bus.st, bus.en_steer, bus.rider_off);
    end
  endtask

  task automatic test_steer_imb;
    load(12'h1F0, 12'h0B0);
    tick(3);
    nvec++;
    if (bus.st !== 2'd2 || bus.en_steer !== 1'b1) begin
      nerr++; $display("FAIL steer_small_imb st=%0d en=%0b exp 2/1", bus.st, bus.en_steer);
    end
    load(12'h0E0, 12'h0E0);
    tick(3);
    nvec++;
    if (bus.st !== 2'd2 || bus.en_steer !== 1'b1) begin
      nerr++; $display("FAIL steer_lo_edge st=%0d en=%0b exp 2/1", bus.st, bus.en_steer);
    end
    load(12'h150, 12'h150);
    tick(1);
  endtask

  task automatic test_dip;
    int bad;
    bad = 0;
    load(12'h080, 12'h080);
    tick(1);
    nvec++;
    if (bus.st !== 2'd3 || bus.en_steer !== 1'b1 || bus.rider_off !== 1'b0) begin
      nerr++; $display("FAIL dip_entry st=%0d en=%0b roff=%0b exp 3/1/0", bus.st, bus.en_steer, bus.rider_off);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.st !== 2'd3 || bus.en_steer !== 1'b1 || bus.rider_off !== 1'b0) bad++;
    end
    load(12'h150, 12'h150);
    if (bus.st !== 2'd3 || bus.en_steer !== 1'b1 || bus.rider_off !== 1'b0) bad++;
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL dip_hold bad_cycles=%0d exp 0", bad);
    end
    tick(1);
    nvec++;
    if (bus.st !== 2'd2 || bus.en_steer !== 1'b1 || bus.rider_off !== 1'b0) begin
      nerr++; $display("FAIL dip_recover st=%0d en=%0b roff=%0b exp 2/1/0", bus.st, bus.en_steer, bus.rider_off);
    end
  endtask

  task automatic test_exit_off;
    load(12'h080, 12'h080);
    tick(1);
    nvec++;
    if (bus.st !== 2'd3 || bus.en_steer !== 1'b1) begin
      nerr++; $display("FAIL exit_entry st=%0d en=%0b exp 3/1", bus.st, bus.en_steer);
    end
    tick(15);
    nvec++;
    if (bus.st !== 2'd3 || bus.en_steer !== 1'b1 || bus.rider_off !== 1'b0) begin
      nerr++; $display("FAIL exit_early st=%0d en=%0b roff=%0b exp 3/1/0", bus.st, bus.en_steer, bus.rider_off);
    end
    tick(1);
    nvec++;
    if (bus.st !== 2'd0 || bus.en_steer !== 1'b0 || bus.rider_off !== 1'b1) begin
      nerr++; $display("FAIL exit_off st=%0d en=%0b roff=%0b exp 0/0/1", bus.st, bus.en_steer, bus.rider_off);
    end
  endtask

  task automatic test_no_vld;
    bus.ld_vld = 1'b0; bus.lft_ld = 12'h150; bus.rght_ld = 12'h150;
    tick(5);
    nvec++;
    if (bus.st !== 2'd0 || bus.rider_off !== 1'b1) begin
      nerr++; $display("FAIL no_vld st=%0d roff=%0b exp 0/1", bus.st, bus.rider_off);
    end
  endtask

  task automatic test_hi_edge;
    load(12'h120, 12'h120);
    tick(3);
    nvec++;
    if (bus.st !== 2'd0 || bus.rider_off !== 1'b1) begin
      nerr++; $display("FAIL hi_edge st=%0d roff=%0b exp 0/1", bus.st, bus.rider_off);
    end
  endtask

  task automatic test_settle_imb;
    load(12'h150, 12'h150);
    tick(1);
    load(12'h1F0, 12'h0B0);
    tick(999);
    nvec++;
    if (bus.st !== 2'd1 || bus.en_steer !== 1'b0) begin
      nerr++; $display("FAIL settle_imb_hold st=%0d en=%0b exp 1/0", bus.st, bus.en_steer);
    end
    load(12'h150, 12'h150);
    tick(32767);
    nvec++;
    if (bus.st !== 2'd1 || bus.en_steer !== 1'b0) begin
      nerr++; $display("FAIL rebal_early st=%0d en=%0b exp 1/0", bus.st, bus.en_steer);
    end
    tick(1);
    nvec++;
    if (bus.st !== 2'd2 || bus.en_steer !== 1'b1) begin
      nerr++; $display("FAIL rebal_done st=%0d en=%0b exp 2/1", bus.st, bus.en_steer);
    end
  endtask

  task automatic test_big_imb;
    load(12'h2A0, 12'h000);
    nvec++;
    if (bus.st !== 2'd2) begin
      nerr++; $display("FAIL big_imb_capture st=%0d exp 2", bus.st);
    end
    tick(1);
    nvec++;
    if (bus.st !== 2'd1 || bus.en_steer !== 1'b0 || bus.rider_off !== 1'b0) begin
      nerr++; $display("FAIL big_imb st=%0d en=%0b roff=%0b exp 1/0/0", bus.st, bus.en_steer, bus.rider_off);
    end
  endtask

  task automatic test_reset_mid;
    load(12'h150, 12'h150);
    tick(10);
    nvec++;
    if (bus.st !== 2'd1) begin
      nerr++; $display("FAIL pre_reset st=%0d exp 1", bus.st);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (bus.st !== 2'd0 || bus.rider_off !== 1'b1 || bus.en_steer !== 1'b0) begin
      nerr++; $display("FAIL async_reset st=%0d roff=%0b en=%0b exp 0/1/0", bus.st, bus.rider_off, bus.en_steer);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    nvec++;
    if (bus.st !== 2'd0 || bus.rider_off !== 1'b1) begin
      nerr++; $display("FAIL post_reset st=%0d roff=%0b exp 0/1", bus.st, bus.rider_off);
    end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_steer_imb();
    test_dip();
    test_exit_off();
    test_no_vld();
    test_hi_edge();
    test_settle_imb();
    test_big_imb();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
